perceptron_pot_pipe: RTL and testbench
======================================

PERCEPTRON_POT_PIPE -- requirements
Module: perceptron_pot_pipe

Interface
REQ-001 SHALL have parameter N_IN, default 16, terms per neuron (legal range 4..1024).
REQ-002 SHALL have parameter ACC_W, default 40, signed accumulator/output width.
REQ-003 SHALL have parameter FRAC, default 24, fractional bits of accumulator fixed-point format.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  input beat valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a beat when in_valid and in_ready are both high.
REQ-008 SHALL have port in_data  input  32  IEEE-754 single-precision input.
REQ-009 SHALL have port in_w  input  6  power-of-two weight: bit5 sign, bits4:0 two's-complement exponent k in -16..15.
REQ-010 SHALL have port out_valid  output  1  neuron result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port out_data  output  ACC_W  signed fixed-point result, FRAC fractional bits.
REQ-013 SHALL have port out_ovf  output  1  saturation occurred in this neuron, valid with out_valid.

Function
REQ-014 Term SHALL equal (-1)^(in_data[31] xor in_w[5]) * 1.m * 2^(e-127+k), with e = in_data[30:23] and m = in_data[22:0].
REQ-015 Exponent adjust SHALL be computed by adding k to the exponent; no multiplier SHALL be used.
REQ-016 e==0 (zero or denormal) SHALL produce term 0 with no overflow flag.
REQ-017 e==255 (inf/NaN) SHALL produce a term at the maximum magnitude with the product sign, and SHALL set the neuron overflow flag.
REQ-018 Conversion SHALL shift {1,m} by (e-127+k+FRAC-23): left if positive, right with truncation of magnitude if negative; shifts of -25 or less SHALL give 0.
REQ-019 Magnitude exceeding 2^(ACC_W-1)-1 SHALL saturate to that magnitude and set the overflow flag; negation SHALL be applied after saturation.
REQ-020 Pipeline SHALL be: S1 decode/exponent-adjust register, S2 signed fixed-point term register, S3 saturating accumulate.
REQ-021 Accumulator add SHALL saturate to +2^(ACC_W-1)-1 or -2^(ACC_W-1)+1 and set the overflow flag.
REQ-022 A beat counter SHALL count accepted beats 0..N_IN-1 and wrap to 0 after N_IN-1; each beat SHALL be tagged first/last through the pipeline.
REQ-023 A first-tagged term SHALL load the accumulator (no add) and clear the overflow flag, so back-to-back neurons need no idle cycle.
REQ-024 Last beat accepted on edge t SHALL cause out_valid high after edge t+3, with out_data and out_ovf held stable until out_valid and out_ready are both high.
REQ-025 in_ready SHALL equal NOT(out_valid AND NOT out_ready); in-flight beats SHALL still drain into the accumulator during a stall.
REQ-026 out_valid SHALL clear on handshake unless a new result is written on the same edge, in which case it SHALL stay high with the new data.
REQ-027 With in_valid held high, in_ready high and out_ready high, throughput SHALL be one beat per cycle.

Reset
REQ-028 Reset assertion SHALL immediately clear out_valid, out_data, out_ovf, the accumulator, the beat counter and all pipeline valids, including mid-neuron; partial sums SHALL be discarded.
REQ-029 in_ready SHALL be 1 during and after reset.

Configuration
REQ-030 With macro PERCEPTRON_RELU_EN defined, out_data SHALL be max(acc,0) at the output register, and out_ovf SHALL be unchanged.
REQ-031 Without PERCEPTRON_RELU_EN, out_data SHALL be the signed accumulator value.

Verification (N_IN=4, ACC_W=40, FRAC=24)
REQ-032 Case 1: four beats of 0x3F800000 with w=0x00, back-to-back -> out_data=0x0004000000, out_ovf=0, out_valid on the 3rd edge after the last beat.
REQ-033 Case 2: beats 0x40000000 w=0x01, 0x3F800000 w=0x20, 0x00000000 w=0x0F, 0x3F000000 w=0x3F -> term values 4,-1,0,-0.25 -> out_data=0x0002C00000.
REQ-034 Case 3: one beat 0x7F800000 (inf) plus three beats of 1.0 -> out_data=0x7FFFFFFFFF and out_ovf=1; next neuron of four 1.0 beats -> 0x0004000000 and out_ovf=0.
REQ-035 Case 4: out_ready low for 10 cycles with continuous input -> in_ready low after the first result, no lost or duplicated results, and the second result correct after out_ready rises.
REQ-036 Case 5: assert rst_n low after 2 beats -> all outputs 0 immediately; four fresh 1.0 beats -> 0x0004000000.
REQ-037 Case 6 (PERCEPTRON_RELU_EN defined): four beats of -1.0 (0xBF800000, w=0x00) -> out_data=0; without the macro -> 0xFFFC000000.

Source files
------------

// File: rtl/perceptron_pot_pipe.sv
// Pipelined perceptron potential: float inputs times power-of-two weights, saturating fixed-point sum.
// Optional ReLU on the result register when PERCEPTRON_RELU_EN is defined.
module perceptron_pot_pipe #(
  parameter int N_IN  = 16,
  parameter int ACC_W = 40,
  parameter int FRAC  = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_data,
  input  logic [5:0]              in_w,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_ovf
);

  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int WW    = ACC_W + 24;
  localparam logic signed [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   MAX_EXT = {2'b00, {(ACC_W-1){1'b1}}};

  // Returns {ovf, magnitude}; magnitude is already clamped to MAX_POS.
  function automatic logic [ACC_W:0] term_mag(input logic zero, input logic inf,
                                              input logic [23:0] mant,
                                              input logic signed [15:0] sh);
    logic [WW-1:0] wide;
    logic [ACC_W:0] res;
    wide = '0;
    if (sh >= $signed(16'(ACC_W)))
      wide = '1;
    else if (sh >= 0)
      wide = WW'(mant) << sh;
    else if (sh > -16'sd25)
      wide = WW'(mant) >> (-sh);
    if (zero)
      res = '0;
    else if (inf || (wide > WW'(MAX_POS)))
      res = {1'b1, MAX_POS};
    else
      res = {1'b0, wide[ACC_W-1:0]};
    return res;
  endfunction

  // Symmetric saturation: the most negative code is never produced.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    logic [ACC_W:0] res;
    s = (ACC_W+1)'(a) + (ACC_W+1)'(b);
    if (s > MAX_EXT)
      res = {1'b1, MAX_POS};
    else if (s < -MAX_EXT)
      res = {1'b1, -MAX_POS};
    else
      res = {1'b0, s[ACC_W-1:0]};
    return res;
  endfunction

  function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] a);
`ifdef PERCEPTRON_RELU_EN
    return a[ACC_W-1] ? '0 : a;
`else
    return a;
`endif
  endfunction

  logic             accept;
  logic [CNT_W-1:0] cnt;
  logic             beat_first, beat_last;
  logic signed [15:0] exp_s, k_s, sh_s;

  assign in_ready   = !(out_valid && !out_ready);
  assign accept     = in_valid && in_ready;
  assign beat_first = (cnt == '0);
  assign beat_last  = (cnt == CNT_W'(N_IN - 1));
  assign exp_s      = {8'd0, in_data[30:23]};
  assign k_s        = {{11{in_w[4]}}, in_w[4:0]};
  assign sh_s       = exp_s + k_s + 16'(FRAC - 150);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (accept)
      cnt <= beat_last ? '0 : cnt + 1'b1;
  end

  // Stage 1: decode and exponent adjust
  logic               vld_p1, first_p1, last_p1, sign_p1, zero_p1, inf_p1;
  logic [23:0]        mant_p1;
  logic signed [15:0] sh_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      first_p1 <= beat_first;
      last_p1  <= beat_last;
      sign_p1  <= in_data[31] ^ in_w[5];
      zero_p1  <= (in_data[30:23] == 8'd0);
      inf_p1   <= (in_data[30:23] == 8'hFF);
      mant_p1  <= {1'b1, in_data[22:0]};
      sh_p1    <= sh_s;
    end
  end

  // Stage 2: signed fixed-point term
  logic                    vld_p2, first_p2, last_p2, tovf_p2;
  logic signed [ACC_W-1:0] term_p2;
  logic [ACC_W:0]          mag_p1;

  assign mag_p1 = term_mag(zero_p1, inf_p1, mant_p1, sh_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p2 <= 1'b0;
    else        vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    if (vld_p1) begin
      first_p2 <= first_p1;
      last_p2  <= last_p1;
      tovf_p2  <= mag_p1[ACC_W];
      term_p2  <= sign_p1 ? -signed'(mag_p1[ACC_W-1:0]) : signed'(mag_p1[ACC_W-1:0]);
    end
  end

  // Stage 3: saturating accumulate
  logic signed [ACC_W-1:0] acc_p3;
  logic                    aovf_p3, done_p3;
  logic [ACC_W:0]          sum_p2;

  assign sum_p2 = sat_add(acc_p3, term_p2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p3  <= '0;
      aovf_p3 <= 1'b0;
      done_p3 <= 1'b0;
    end else begin
      done_p3 <= vld_p2 && last_p2;
      if (vld_p2) begin
        if (first_p2) begin
          acc_p3  <= term_p2;
          aovf_p3 <= tovf_p2;
        end else begin
          acc_p3  <= signed'(sum_p2[ACC_W-1:0]);
          aovf_p3 <= aovf_p3 | tovf_p2 | sum_p2[ACC_W];
        end
      end
    end
  end

  // Result register: held until handshake, overwritten only by a new neuron
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (done_p3) begin
      out_valid <= 1'b1;
      out_data  <= relu(acc_p3);
      out_ovf   <= aovf_p3;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_perceptron_pot_pipe.sv
// Bench for perceptron_pot_pipe: directed cases plus randomized traffic against a real-arithmetic model.
module tb_perceptron_pot_pipe;
  localparam int N_IN  = 4;
  localparam int ACC_W = 40;
  localparam int FRAC  = 24;
  localparam longint MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [31:0]             in_data = '0;
  logic [5:0]              in_w = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic signed [ACC_W-1:0] out_data;
  logic                    out_ovf;

  always #5 clk = ~clk;

  perceptron_pot_pipe #(.N_IN(N_IN), .ACC_W(ACC_W), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_w(in_w), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  int n_checks = 0, n_errors = 0, cyc = 0;
  logic [37:0] src_q[$];
  longint exp_q[$];
  bit     ovf_q[$];
  int     lt_q[$];
  int     mcnt = 0;
  longint macc = 0;
  bit     movf = 1'b0;
  int     ready_pct = 100, valid_pct = 100;
  bit     chk_lat = 1'b0, stall_chk = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Exact value of the term as a real, truncated toward zero into the fixed-point grid.
  function automatic longint model_term(input logic [31:0] d, input logic [5:0] w, output bit ovf);
    int     e, k, p;
    real    mag;
    longint m;
    e = int'(d[30:23]);
    k = $signed(w[4:0]);
    p = e - 127 + k + FRAC - 23;
    ovf = 1'b0;
    if (e == 0) return 0;
    if (e == 255) begin
      ovf = 1'b1;
      m = MAXV;
    end else begin
      mag = real'({1'b1, d[22:0]});
      if (p > 0) repeat (p) mag = mag * 2.0;
      else repeat (-p) mag = mag / 2.0;
      if (mag > real'(MAXV)) begin
        ovf = 1'b1;
        m = MAXV;
      end else begin
        m = longint'($floor(mag));
      end
    end
    return (d[31] ^ w[5]) ? -m : m;
  endfunction

  task automatic model_accept(input logic [31:0] d, input logic [5:0] w);
    bit     o;
    longint t, s;
    t = model_term(d, w, o);
    if (mcnt == 0) begin
      macc = t;
      movf = o;
    end else begin
      s = macc + t;
      if (s > MAXV) begin s = MAXV; movf = 1'b1; end
      else if (s < -MAXV) begin s = -MAXV; movf = 1'b1; end
      macc = s;
      movf = movf | o;
    end
    mcnt++;
    if (mcnt == N_IN) begin
      mcnt = 0;
`ifdef PERCEPTRON_RELU_EN
      exp_q.push_back(macc < 0 ? 0 : macc);
`else
      exp_q.push_back(macc);
`endif
      ovf_q.push_back(movf);
      lt_q.push_back(cyc);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [5:0] w);
    src_q.push_back({w, d});
  endtask

  task automatic tick();
    logic [37:0] b;
    longint      ed;
    bit          eo;
    int          lt;
    @(negedge clk);
    out_ready = ($urandom_range(0, 99) < ready_pct);
    if (src_q.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
      b = src_q[0];
      in_valid = 1'b1;
      in_data  = b[31:0];
      in_w     = b[37:32];
    end else begin
      in_valid = 1'b0;
    end
    #1;
    if (out_valid && out_ready) begin
      check("result_pending", longint'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        ed = exp_q.pop_front();
        eo = ovf_q.pop_front();
        lt = lt_q.pop_front();
        check("out_data", longint'(out_data), ed);
        check("out_ovf", longint'(out_ovf), longint'(eo));
        if (chk_lat) check("latency", cyc - lt, 4);
      end
    end
    if (stall_chk)
      check("in_ready_rule", longint'(in_ready), longint'(!(out_valid && !out_ready)));
    if (in_valid && in_ready) begin
      model_accept(in_data, in_w);
      void'(src_q.pop_front());
    end
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", src_q.size() + exp_q.size(), 0);
  endtask

  function automatic logic [31:0] rand_float();
    int          r;
    logic [7:0]  e;
    logic [22:0] m;
    logic        s;
    r = $urandom_range(0, 99);
    if (r < 5)      e = 8'd0;
    else if (r < 8) e = 8'hFF;
    else            e = 8'($urandom_range(110, 150));
    m = 23'($urandom());
    s = 1'($urandom_range(0, 1));
    return {s, e, m};
  endfunction

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_out_ovf", longint'(out_ovf), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Four 1.0 beats, back-to-back, with latency measured
    chk_lat = 1'b1;
    repeat (4) push(32'h3F800000, 6'h00);
    drain(50);
    chk_lat = 1'b0;

    // Mixed exponents, signs and a zero input
    push(32'h40000000, 6'h01);
    push(32'h3F800000, 6'h20);
    push(32'h00000000, 6'h0F);
    push(32'h3F000000, 6'h3F);
    drain(50);

    // Infinity saturates; the next neuron starts clean
    push(32'h7F800000, 6'h00);
    repeat (3) push(32'h3F800000, 6'h00);
    repeat (4) push(32'h3F800000, 6'h00);
    drain(50);

    // Output stall with continuous input
    for (int i = 0; i < 8; i++) push(32'h3F800000 + 32'(i << 20), 6'(i));
    ready_pct = 0;
    stall_chk = 1'b1;
    repeat (10) tick();
    check("stall_in_ready", longint'(in_ready), 0);
    check("stall_out_valid", longint'(out_valid), 1);
    ready_pct = 100;
    drain(100);
    stall_chk = 1'b0;

    // Reset in the middle of a neuron while a result is held
    ready_pct = 0;
    repeat (6) push(32'h3F800000, 6'h00);
    repeat (10) tick();
    check("pre_reset_valid", longint'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", longint'(out_valid), 0);
    check("mid_rst_out_data", longint'(out_data), 0);
    check("mid_rst_out_ovf", longint'(out_ovf), 0);
    check("mid_rst_in_ready", longint'(in_ready), 1);
    src_q.delete();
    exp_q.delete();
    ovf_q.delete();
    lt_q.delete();
    mcnt = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ready_pct = 100;
    repeat (4) push(32'h3F800000, 6'h00);
    drain(50);

    // Negative result, clamped only when ReLU is built in
    repeat (4) push(32'hBF800000, 6'h00);
    drain(50);

    // Random traffic with random back-pressure and input gaps
    ready_pct = 70;
    valid_pct = 80;
    for (int i = 0; i < 40 * N_IN; i++) push(rand_float(), 6'($urandom()));
    drain(3000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
